// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling, 3-sample majority vote,
// start-bit glitch rejection and stop-bit framing error pulse.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OSR      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int D0 = CLK_FREQ / (9600 * OSR);
  localparam int D1 = CLK_FREQ / (19200 * OSR);
  localparam int D2 = CLK_FREQ / (38400 * OSR);
  localparam int D3 = CLK_FREQ / (57600 * OSR);
  localparam int D4 = CLK_FREQ / (115200 * OSR);
  localparam int DW = $clog2(D0);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_max_q;
  logic [3:0]    s_q;
  logic [2:0]    b_q;
  logic          v6_q;
  logic          v7_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          done_q;
  logic          ferr_q;
  logic          busy_q;

  logic start_edge;
  logic tick;
  logic vote;
  logic mid;
  logic bit_end;

  function automatic logic [DW-1:0] div_max(input logic [3:0] sel);
    case (sel)
      4'd1:    div_max = DW'(D1 - 1);
      4'd2:    div_max = DW'(D2 - 1);
      4'd3:    div_max = DW'(D3 - 1);
      4'd4:    div_max = DW'(D4 - 1);
      default: div_max = DW'(D0 - 1);
    endcase
  endfunction

  // Synchronizer resets high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start_edge = prev_q & ~sync2_q;
  assign tick       = (div_q == div_max_q);
  assign mid        = tick && (s_q == 4'd8);
  assign bit_end    = tick && (s_q == 4'd15);
  assign vote       = (v6_q & v7_q) | (v6_q & sync2_q) | (v7_q & sync2_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      div_max_q <= '0;
      s_q       <= '0;
      b_q       <= '0;
      v6_q      <= 1'b1;
      v7_q      <= 1'b1;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      if (state_q == IDLE) begin
        div_q <= '0;
        s_q   <= '0;
      end else begin
        div_q <= tick ? '0 : div_q + DW'(1);
        if (tick) s_q <= s_q + 4'd1;
      end
      if (tick && s_q == 4'd6) v6_q <= sync2_q;
      if (tick && s_q == 4'd7) v7_q <= sync2_q;
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q   <= START;
            busy_q    <= 1'b1;
            b_q       <= '0;
            div_max_q <= div_max(baud_set);
          end
        end
        START: begin
          if (mid && vote) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (mid) shift_q[b_q] <= vote;
          if (bit_end) begin
            if (b_q == 3'd7) state_q <= STOP;
            else b_q <= b_q + 3'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (mid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (vote) begin
              data_q <= shift_q;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_byte = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: serial frames driven at chosen rates, results
// compared with a frame-level model of expected bytes and errors.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 9_216_000;
  localparam int DIV0 = CLK_FREQ / (9600 * 16);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] baud_set = 4'd0;
  logic       rs232_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_set (baud_set),
    .rs232_rx (rs232_rx),
    .data_byte(data_byte),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  int n_checks = 0;
  int n_pass = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         clash_cnt = 0;
  int         long_cnt = 0;
  logic [7:0] got_q[$];
  logic       last_done = 1'b0;
  logic       last_ferr = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  logic [7:0] model_last = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      last_done = 1'b0;
      last_ferr = 1'b0;
    end else begin
      if (rx_done) begin
        done_cnt++;
        got_q.push_back(data_byte);
      end
      if (frame_err) ferr_cnt++;
      if (rx_done && frame_err) clash_cnt++;
      if ((rx_done && last_done) || (frame_err && last_ferr)) long_cnt++;
      last_done = rx_done;
      last_ferr = frame_err;
    end
  end

  function automatic real baud_of(input logic [3:0] sel);
    case (sel)
      4'd1:    return 19200.0;
      4'd2:    return 38400.0;
      4'd3:    return 57600.0;
      4'd4:    return 115200.0;
      default: return 9600.0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    done_cnt  = 0;
    ferr_cnt  = 0;
    clash_cnt = 0;
    long_cnt  = 0;
    got_q.delete();
    exp_q.delete();
    exp_ferr = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input real bitclk,
                            input logic stop);
    logic [9:0] bits;
    int cyc;
    bits = {stop, d, 1'b0};
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      rs232_rx = bits[i];
      while (cyc < int'((i + 1) * bitclk)) begin
        @(negedge clk);
        cyc++;
      end
    end
    rs232_rx = 1'b1;
  endtask

  // Frame-level model: a good stop bit delivers the byte, a low one
  // raises a framing error and keeps the previous byte.
  task automatic model_send(input logic [7:0] d, input real bitclk,
                            input logic stop);
    send_frame(d, bitclk, stop);
    if (stop) begin
      exp_q.push_back(d);
      model_last = d;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (!rx_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(4);
    n_checks++; if (data_byte !== 8'h00) $display("FAIL rst_data: got %h want 00", data_byte); else n_pass++;
    n_checks++; if (rx_done !== 1'b0) $display("FAIL rst_done: got %b want 0", rx_done); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_ferr: got %b want 0", frame_err); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", rx_busy); else n_pass++;
    rst = 1'b1;
    clear_mon();
    model_last = 8'h00;
    idle(20);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL rel_busy: got %b want 0", rx_busy); else n_pass++;
  endtask

  task automatic test_frame_err();
    bit ok;
    baud_set = 4'd1;
    clear_mon();
    model_send(8'h3C, CLK_FREQ / baud_of(4'd1), 1'b0);
    idle(100);
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL ferr_idle: busy stuck got %b want 1", ok); else n_pass++;
    n_checks++; if (ferr_cnt !== exp_ferr) $display("FAIL ferr_cnt: got %0d want %0d", ferr_cnt, exp_ferr); else n_pass++;
    n_checks++; if (done_cnt !== 0) $display("FAIL ferr_done: got %0d want 0", done_cnt); else n_pass++;
    n_checks++; if (data_byte !== model_last) $display("FAIL ferr_data: got %h want %h", data_byte, model_last); else n_pass++;
    n_checks++; if (long_cnt !== 0) $display("FAIL ferr_len: got %0d long pulses want 0", long_cnt); else n_pass++;
  endtask

  task automatic test_two_frames();
    bit ok;
    logic [8:0] got;
    baud_set = 4'd4;
    clear_mon();
    model_send(8'h55, CLK_FREQ / baud_of(4'd4), 1'b1);
    model_send(8'hA3, CLK_FREQ / baud_of(4'd4), 1'b1);
    idle(50);
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL two_idle: got %b want 1", ok); else n_pass++;
    n_checks++; if (done_cnt !== exp_q.size()) $display("FAIL two_cnt: got %0d want %0d", done_cnt, exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < got_q.size()) ? {1'b0, got_q[k]} : 9'h100;
      n_checks++; if (got !== {1'b0, exp_q[k]}) $display("FAIL two_byte%0d: got %h want %h", k, got, exp_q[k]); else n_pass++;
    end
    n_checks++; if (ferr_cnt !== 0) $display("FAIL two_ferr: got %0d want 0", ferr_cnt); else n_pass++;
    n_checks++; if (data_byte !== model_last) $display("FAIL two_hold: got %h want %h", data_byte, model_last); else n_pass++;
  endtask

  task automatic test_glitch();
    baud_set = 4'd0;
    clear_mon();
    rs232_rx = 1'b0;
    idle(3 * DIV0);
    rs232_rx = 1'b1;
    idle(9 * DIV0 - 15 - 3 * DIV0);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_hi: got %b want 1", rx_busy); else n_pass++;
    idle(35);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_lo: got %b want 0", rx_busy); else n_pass++;
    idle(300);
    n_checks++; if (done_cnt !== 0) $display("FAIL glitch_done: got %0d want 0", done_cnt); else n_pass++;
    n_checks++; if (ferr_cnt !== 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [8:0] got;
    real bc;
    baud_set = 4'd2;
    bc = CLK_FREQ / baud_of(4'd2) / 1.025;
    clear_mon();
    model_send(8'h00, bc, 1'b1);
    model_send(8'hFF, bc, 1'b1);
    idle(50);
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b_idle: got %b want 1", ok); else n_pass++;
    n_checks++; if (done_cnt !== exp_q.size()) $display("FAIL b2b_cnt: got %0d want %0d", done_cnt, exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < got_q.size()) ? {1'b0, got_q[k]} : 9'h100;
      n_checks++; if (got !== {1'b0, exp_q[k]}) $display("FAIL b2b_byte%0d: got %h want %h", k, got, exp_q[k]); else n_pass++;
    end
    n_checks++; if (ferr_cnt !== 0) $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    real bc;
    baud_set = 4'd0;
    bc = CLK_FREQ / baud_of(4'd0);
    clear_mon();
    fork
      send_frame(8'hF0, bc, 1'b1);
      begin
        idle(int'(5.5 * bc));
        rst = 1'b0;
        idle(2);
        n_checks++; if (data_byte !== 8'h00) $display("FAIL rmid_data: got %h want 00", data_byte); else n_pass++;
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", rx_busy); else n_pass++;
        n_checks++; if ({rx_done, frame_err} !== 2'b00) $display("FAIL rmid_pulse: got %b want 00", {rx_done, frame_err}); else n_pass++;
        idle(20);
        rst = 1'b1;
        model_last = 8'h00;
      end
    join
    idle(20);
    model_send(8'h81, bc, 1'b1);
    idle(50);
    wait_idle(ok);
    n_checks++; if (done_cnt !== 1) $display("FAIL rmid_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (data_byte !== model_last) $display("FAIL rmid_byte: got %h want %h", data_byte, model_last); else n_pass++;
    n_checks++; if (ferr_cnt !== 0) $display("FAIL rmid_ferr: got %0d want 0", ferr_cnt); else n_pass++;
  endtask

  task automatic test_baud_latch();
    bit ok;
    real bc;
    baud_set = 4'd15;
    bc = CLK_FREQ / baud_of(4'd15);
    clear_mon();
    fork
      model_send(8'h7E, bc, 1'b1);
      begin
        idle(int'(3.0 * bc));
        baud_set = 4'd4;
      end
    join
    idle(50);
    wait_idle(ok);
    n_checks++; if (done_cnt !== 1) $display("FAIL latch_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (data_byte !== model_last) $display("FAIL latch_byte: got %h want %h", data_byte, model_last); else n_pass++;
    n_checks++; if (ferr_cnt !== 0) $display("FAIL latch_ferr: got %0d want 0", ferr_cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    logic [8:0] got;
    logic [7:0] d;
    logic       stop;
    real        bc;
    clear_mon();
    for (int f = 0; f < 10; f++) begin
      baud_set = 4'($urandom_range(2, 4));
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      bc = CLK_FREQ / baud_of(baud_set) *
           (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
      model_send(d, bc, stop);
      idle($urandom_range(5, 30));
    end
    idle(50);
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rnd_idle: got %b want 1", ok); else n_pass++;
    n_checks++; if (done_cnt !== exp_q.size()) $display("FAIL rnd_cnt: got %0d want %0d", done_cnt, exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < got_q.size()) ? {1'b0, got_q[k]} : 9'h100;
      n_checks++; if (got !== {1'b0, exp_q[k]}) $display("FAIL rnd_byte%0d: got %h want %h", k, got, exp_q[k]); else n_pass++;
    end
    n_checks++; if (ferr_cnt !== exp_ferr) $display("FAIL rnd_ferr: got %0d want %0d", ferr_cnt, exp_ferr); else n_pass++;
    n_checks++; if (data_byte !== model_last) $display("FAIL rnd_hold: got %h want %h", data_byte, model_last); else n_pass++;
    n_checks++; if (clash_cnt !== 0) $display("FAIL rnd_clash: got %0d want 0", clash_cnt); else n_pass++;
    n_checks++; if (long_cnt !== 0) $display("FAIL rnd_len: got %0d want 0", long_cnt); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame_err();
    test_two_frames();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_baud_latch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
